// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants: schedule FSM states, S-box and rcon helpers
//
// Purpose : common types and pure functions used by the key schedule controller
//           and its single-round step.
// Ports   : none (package).
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } ks_state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    // Round constant for the round key being produced (1..10); zero elsewhere.
    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_round_fn.sv
// rtl/key_round_fn.sv - one AES-128 key expansion step (previous round key -> next)
//
// Purpose : purely combinational: RotWord, SubWord, rcon XOR, then chained word XORs.
// Ports   : i_prev_key [127:0] previous round key, word 0 in [127:96]
//           i_rcon     [7:0]   round constant for the key being produced
//           o_next_key [127:0] next round key
module key_round_fn
    import aes_pkg::*;
(
    input  logic [127:0] i_prev_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_prev_key[127:96];
    assign w_w1 = i_prev_key[95:64];
    assign w_w2 = i_prev_key[63:32];
    assign w_w3 = i_prev_key[31:0];

    // RotWord is a one-byte left rotate of the last word before substitution.
    assign w_temp = aes_sub_word({w_w3[23:0], w_w3[31:24]}) ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 round key expansion controller with 11-entry key store
//
// Purpose : accepts a cipher key, expands one round key per cycle into local storage,
//           and serves combinational reads of the stored round keys.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           key_valid, key_in   cipher key offer (word 0 in [127:96])
//           key_ready           key can be accepted this cycle
//           rk_lock             consumer holds the stored keys; blocks reload
//           rk_rd_idx           round key read index (11..15 read as zero)
//           rk_rd_data          round key at rk_rd_idx
//           keys_valid          all 11 round keys stored and consistent
//           busy                expansion in progress
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    input  logic         rk_lock,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         keys_valid,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ks_state_t    r_state;
    logic [3:0]   r_cnt;
    logic         r_keys_valid;
    logic [127:0] r_rk [0:NR];

    logic         w_accept;
    logic [127:0] w_prev_key;
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon;

    assign key_ready  = (r_state == ST_IDLE) || ((r_state == ST_READY) && !rk_lock);
    assign w_accept   = key_valid && key_ready;
    assign busy       = (r_state == ST_EXPAND);
    assign keys_valid = r_keys_valid;

    // Counter is 1..NR while expanding; outside EXPAND the selected value is unused.
    assign w_prev_key = (r_cnt != 4'd0) ? r_rk[r_cnt - 4'd1] : '0;
    assign w_rcon     = aes_rcon(r_cnt);

    assign rk_rd_data = (rk_rd_idx <= LAST_ROUND) ? r_rk[rk_rd_idx] : '0;

    key_round_fn u_round (
        .i_prev_key (w_prev_key),
        .i_rcon     (w_rcon),
        .o_next_key (w_next_key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_rk[i] <= '0;
            end
        end else if (w_accept) begin
            // Acceptance is possible from IDLE or READY; both restart the schedule.
            r_rk[0]      <= key_in;
            r_cnt        <= 4'd1;
            r_keys_valid <= 1'b0;
            r_state      <= ST_EXPAND;
        end else if (r_state == ST_EXPAND) begin
            r_rk[r_cnt] <= w_next_key;
            if (r_cnt == LAST_ROUND) begin
                // Parking the counter at zero keeps it from ever reaching NR+1.
                r_cnt        <= 4'd0;
                r_keys_valid <= 1'b1;
                r_state      <= ST_READY;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl
module tb_key_schedule_ctrl;

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_ZERO  = 128'h0;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         rk_lock = 1'b0;
    logic [3:0]   rk_rd_idx = 4'd0;
    logic [127:0] rk_rd_data;
    logic         keys_valid;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    key_schedule_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .rk_lock    (rk_lock),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference AES key expansion (independent of the RTL tables)
    logic [7:0] tb_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return 8'((v << k) | (v >> (8 - k)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xv;
        for (int x = 0; x < 256; x++) begin
            xv = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = (rc[7]) ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    // ---------------- behavioural model: edges elapsed since the last acceptance
    logic [127:0] m_rk [11];
    logic [127:0] m_key = '0;
    int           m_n = 0;
    bit           m_have = 1'b0;

    function automatic bit exp_busy();
        return m_have && (m_n < 10);
    endfunction

    function automatic bit exp_kv();
        return m_have && (m_n >= 10);
    endfunction

    function automatic bit exp_ready();
        return m_have ? (m_n >= 10 && !rk_lock) : 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have <= 1'b0;
            m_n    <= 0;
            for (int i = 0; i < 11; i++) m_rk[i] <= '0;
        end else if (key_valid && exp_ready()) begin
            m_key   <= key_in;
            m_rk[0] <= key_in;
            m_n     <= 0;
            m_have  <= 1'b1;
        end else if (exp_busy()) begin
            m_n <= m_n + 1;
            m_rk[m_n + 1] <= round_key(m_key, m_n + 1);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, exp_busy());
            check("keys_valid", keys_valid, exp_kv());
            check("key_ready", key_ready, exp_ready());
            check("rk_rd_data", rk_rd_data, (rk_rd_idx <= 4'd10) ? m_rk[rk_rd_idx] : 128'h0);
        end
    end

    // ---------------- stimulus helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rk_rd_idx = rk_rd_idx + 4'd1;
        end
    endtask

    task automatic peek(input string nm, input logic [3:0] idx, input logic [127:0] exp);
        rk_rd_idx = idx;
        #1;
        check(nm, rk_rd_data, exp);
    endtask

    // Returns edges counted from the acceptance edge (which counts as 1).
    task automatic wait_kv(input string nm, output int edges);
        int k;
        k = 1;
        while (!keys_valid && k < 40) begin
            @(posedge clk);
            #1;
            rk_rd_idx = rk_rd_idx + 4'd1;
            k++;
        end
        if (!keys_valid) check({nm, "_timeout"}, keys_valid, 1'b1);
        edges = k;
    endtask

    int edges;

    initial begin
        build_sbox();
        check("model_fips_r1", round_key(K_FIPS, 1), FIPS_R1);
        check("model_fips_r10", round_key(K_FIPS, 10), FIPS_R10);
        check("model_zero_r10", round_key(K_ZERO, 10), ZERO_R10);

        // reset state
        @(posedge clk);
        #1;
        check("rst_key_ready", key_ready, 1'b1);
        check("rst_keys_valid", keys_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        peek("rst_rk0", 4'd0, 128'h0);
        step(1);
        rst = 1'b0;
        step(2);

        // FIPS key: latency and known round keys
        key_valid = 1'b1;
        key_in = K_FIPS;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        wait_kv("fips", edges);
        check("kv_latency_edges", edges, 11);
        peek("fips_rk1", 4'd1, FIPS_R1);
        peek("fips_rk10", 4'd10, FIPS_R10);
        peek("rd_idx12_zero", 4'd12, 128'h0);
        step(2);

        // back-to-back zero key, then a second key held through EXPAND
        key_valid = 1'b1;
        key_in = K_ZERO;
        @(posedge clk);
        #1;
        key_in = K_SEQ;
        step(3);
        check("held_key_ready_low", key_ready, 1'b0);
        wait_kv("zero", edges);
        peek("zero_rk10", 4'd10, ZERO_R10);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("second_accepted_busy", busy, 1'b1);
        wait_kv("seq", edges);
        peek("seq_rk10", 4'd10, SEQ_R10);

        // lock blocks reload
        rk_lock = 1'b1;
        key_valid = 1'b1;
        key_in = K_FIPS;
        step(5);
        check("lock_keys_valid", keys_valid, 1'b1);
        check("lock_busy", busy, 1'b0);
        peek("lock_rk0", 4'd0, K_SEQ);
        peek("lock_rk10", 4'd10, SEQ_R10);
        rk_lock = 1'b0;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("unlock_accept_busy", busy, 1'b1);
        peek("unlock_rk0", 4'd0, K_FIPS);
        wait_kv("relock", edges);
        step(1);

        // reset in the middle of an expansion
        key_valid = 1'b1;
        key_in = K_SEQ;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        step(4);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_keys_valid", keys_valid, 1'b0);
        check("midrst_key_ready", key_ready, 1'b1);
        peek("midrst_rk10", 4'd10, 128'h0);
        peek("midrst_rk0", 4'd0, 128'h0);
        step(2);
        rst = 1'b0;
        step(3);
        check("post_rst_idle", busy, 1'b0);
        key_valid = 1'b1;
        key_in = K_FIPS;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_kv("after_rst", edges);
        check("after_rst_latency", edges, 11);
        peek("after_rst_rk1", 4'd1, FIPS_R1);
        peek("after_rst_rk10", 4'd10, FIPS_R10);
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
